// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the datapath's instruction-fetch and load/store
//   ports. The two requesters share one single-port synchronous RAM that has
//   a one-cycle read latency. Each fetched instruction or loaded word is
//   returned with a one-cycle valid/done pulse.
//
//   State table
//     state   | meaning
//     IDLE    | no access in progress; arbitrate and accept a request
//     ACCESS  | RAM sees the latched address (and write strobe on stores)
//     CAPTURE | RAM read data registered into the requester's output
//     RESPOND | one-cycle fetch_valid / ls_done pulse, then back to IDLE
//
//   Ports
//     clk, reset (async, active low)
//     fetch_req, mem_address_PC                  -> data_from_mem_PC, fetch_valid
//     loading, storing, mem_address_load_stor,
//     data_to_mem_stor                           -> data_from_mem_load, ls_done
//     busy                                       high whenever state != IDLE
//     ram_addr, ram_we, ram_wdata (registered)   <- ram_rdata
module mem_responder #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_req,
  input  logic [WIDTH-1:0]     mem_address_PC,
  output logic [WIDTH-1:0]     data_from_mem_PC,
  output logic                 fetch_valid,
  input  logic                 loading,
  input  logic                 storing,
  input  logic [WIDTH-1:0]     mem_address_load_stor,
  input  logic [WIDTH-1:0]     data_to_mem_stor,
  output logic [WIDTH-1:0]     data_from_mem_load,
  output logic                 ls_done,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_we,
  output logic [WIDTH-1:0]     ram_wdata,
  input  logic [WIDTH-1:0]     ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESPOND} state_t;

  state_t state, state_nxt;
  logic   op_fetch;       // latched operation: fetch
  logic   op_store;       // latched operation: store (load when neither)
  logic   last_grant_ls;  // previous grant went to load/store
  logic   req_ls;
  logic   grant_ls;
  logic   grant_fetch;

  // Load/store normally wins, but yields to a waiting fetch right after it
  // has been served, so a stream of data accesses cannot starve fetch.
  assign req_ls      = loading | storing;
  assign grant_ls    = req_ls & ~(last_grant_ls & fetch_req);
  assign grant_fetch = fetch_req & ~grant_ls;

  always_comb begin
    state_nxt   = state;
    busy        = (state != IDLE);
    fetch_valid = 1'b0;
    ls_done     = 1'b0;
    case (state)
      IDLE:    if (grant_ls || grant_fetch) state_nxt = ACCESS;
      ACCESS:  state_nxt = op_store ? RESPOND : CAPTURE;
      CAPTURE: state_nxt = RESPOND;
      RESPOND: begin
        state_nxt   = IDLE;
        fetch_valid = op_fetch;
        ls_done     = ~op_fetch;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      op_fetch           <= 1'b0;
      op_store           <= 1'b0;
      last_grant_ls      <= 1'b0;
      ram_addr           <= '0;
      ram_we             <= 1'b0;
      ram_wdata          <= '0;
      data_from_mem_PC   <= '0;
      data_from_mem_load <= '0;
    end else begin
      state <= state_nxt;

      // ram_addr doubles as the latched request address; upper request
      // address bits beyond ADDR_BITS are dropped so addresses wrap.
      if (state == IDLE && (grant_ls || grant_fetch)) begin
        op_fetch      <= grant_fetch;
        op_store      <= grant_ls & storing;   // load+store together is a store
        last_grant_ls <= grant_ls;
        ram_addr      <= grant_ls ? mem_address_load_stor[ADDR_BITS-1:0]
                                  : mem_address_PC[ADDR_BITS-1:0];
        ram_we        <= grant_ls & storing;
        if (grant_ls && storing) ram_wdata <= data_to_mem_stor;
      end

      if (state == ACCESS) ram_we <= 1'b0;

      if (state == CAPTURE) begin
        if (op_fetch) data_from_mem_PC   <= ram_rdata;
        else          data_from_mem_load <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int W  = 16;
  localparam int AB = 12;   // narrower than W so address wrap is visible
  localparam int K_FETCH = 0, K_LOAD = 1, K_STORE = 2, K_BOTH = 3;

  logic          clk, reset;
  logic          fetch_req, loading, storing;
  logic [W-1:0]  mem_address_PC, mem_address_load_stor, data_to_mem_stor;
  logic [W-1:0]  data_from_mem_PC, data_from_mem_load;
  logic          fetch_valid, ls_done, busy;
  logic [AB-1:0] ram_addr;
  logic          ram_we;
  logic [W-1:0]  ram_wdata, ram_rdata;

  mem_responder #(.WIDTH(W), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .mem_address_PC(mem_address_PC),
    .data_from_mem_PC(data_from_mem_PC), .fetch_valid(fetch_valid),
    .loading(loading), .storing(storing),
    .mem_address_load_stor(mem_address_load_stor), .data_to_mem_stor(data_to_mem_stor),
    .data_from_mem_load(data_from_mem_load), .ls_done(ls_done), .busy(busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] init_val(input int i);
    if (i == 5) return 16'h1234;
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  // Synchronous single-port RAM, read-first, filled on the first clock edge.
  logic [W-1:0] ram [0:(1<<AB)-1];
  bit           ram_loaded;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < (1<<AB); i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  // Reference model: word-level memory image plus the held output values.
  logic [W-1:0] ref_mem [0:(1<<AB)-1];
  logic [W-1:0] exp_pc, exp_ld;

  int n_cmp, n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    fetch_req = 0; loading = 0; storing = 0;
    mem_address_PC = '0; mem_address_load_stor = '0; data_to_mem_stor = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    check("rst ram_addr", ram_addr, 0);
    check("rst ram_we", ram_we, 0);
    check("rst ram_wdata", ram_wdata, 0);
    check("rst data_pc", data_from_mem_PC, 0);
    check("rst data_ld", data_from_mem_load, 0);
    check("rst fetch_valid", fetch_valid, 0);
    check("rst ls_done", ls_done, 0);
    check("rst busy", busy, 0);
    exp_pc = '0; exp_ld = '0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Issue one request at a negedge and follow it to its pulse. Inputs are
  // scrambled while busy to show the latched copies are used.
  task automatic do_op(input int kind, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                       input string tag);
    logic [AB-1:0] a;
    bit seen;
    int lat, we_cnt;
    bit is_store;
    a = addr[AB-1:0];
    is_store = (kind == K_STORE || kind == K_BOTH);
    case (kind)
      K_FETCH: begin fetch_req = 1; mem_address_PC = addr; end
      K_LOAD:  begin loading = 1; mem_address_load_stor = addr; end
      K_STORE: begin storing = 1; mem_address_load_stor = addr; end
      default: begin loading = 1; storing = 1; mem_address_load_stor = addr; end
    endcase
    data_to_mem_stor = wdata;
    seen = 0; lat = 0; we_cnt = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, " ram_addr"}, ram_addr, a);
        check({tag, " busy"}, busy, 1);
        mem_address_PC        = 16'($urandom);
        mem_address_load_stor = 16'($urandom);
        data_to_mem_stor      = 16'($urandom);
      end
      if (ram_we) begin
        we_cnt++;
        check({tag, " we addr"}, ram_addr, a);
        check({tag, " we data"}, ram_wdata, wdata);
      end
      if (fetch_valid || ls_done) begin
        seen = 1;
        lat  = c;
        if (is_store) ref_mem[a] = wdata;
        else if (kind == K_FETCH) exp_pc = ref_mem[a];
        else exp_ld = ref_mem[a];
        check({tag, " latency"}, lat, is_store ? 2 : 3);
        check({tag, " fetch_valid"}, fetch_valid, kind == K_FETCH);
        check({tag, " ls_done"}, ls_done, kind != K_FETCH);
        check({tag, " data_pc"}, data_from_mem_PC, exp_pc);
        check({tag, " data_ld"}, data_from_mem_load, exp_ld);
        check({tag, " we cycles"}, we_cnt, is_store);
      end
    end
    check({tag, " completed"}, seen, 1);
    clear_inputs();
    @(negedge clk);
    check({tag, " pulse one cycle"}, {fetch_valid, ls_done}, 0);
    check({tag, " idle"}, busy, 0);
  endtask

  // Wait for the next pulse; which = 0 fetch, 1 load/store, -1 timeout.
  task automatic wait_pulse(output int which);
    which = -1;
    for (int c = 0; c < 10 && which < 0; c++) begin
      @(negedge clk);
      if (fetch_valid) which = 0;
      else if (ls_done) which = 1;
    end
  endtask

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;   // data_from_mem_PC for fetch, data_from_mem_load otherwise
  } vec_t;

  vec_t vecs [9];

  initial begin
    int w;
    logic [W-1:0] ra, wd;
    vecs[0] = '{K_FETCH, 16'h0005, 16'h0000, 16'h1234};
    vecs[1] = '{K_STORE, 16'h0020, 16'hBEEF, 16'h0000};
    vecs[2] = '{K_LOAD,  16'h0020, 16'h0000, 16'hBEEF};
    vecs[3] = '{K_LOAD,  16'hF020, 16'h0000, 16'hBEEF};
    vecs[4] = '{K_STORE, 16'h0FFF, 16'h0001, 16'hBEEF};
    vecs[5] = '{K_FETCH, 16'h1FFF, 16'h0000, 16'h0001};
    vecs[6] = '{K_BOTH,  16'h0005, 16'hCAFE, 16'hBEEF};
    vecs[7] = '{K_FETCH, 16'h0005, 16'h0000, 16'hCAFE};
    vecs[8] = '{K_LOAD,  16'h0005, 16'h0000, 16'hCAFE};

    n_cmp = 0; n_fail = 0;
    for (int i = 0; i < (1<<AB); i++) ref_mem[i] = init_val(i);
    apply_reset();

    foreach (vecs[i]) begin
      do_op(vecs[i].kind, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i));
      if (vecs[i].kind == K_FETCH) check($sformatf("vec%0d table pc", i), data_from_mem_PC, vecs[i].exp);
      else check($sformatf("vec%0d table ld", i), data_from_mem_load, vecs[i].exp);
    end

    // Arbitration: simultaneous requests after reset -> load first, then fetch.
    apply_reset();
    fetch_req = 1; mem_address_PC = 16'h0040;
    loading = 1;   mem_address_load_stor = 16'h0050;
    wait_pulse(w);
    check("arb1 first is ls", w, 1);
    check("arb1 ld data", data_from_mem_load, ref_mem[12'h050]);
    loading = 0;
    wait_pulse(w);
    check("arb1 second is fetch", w, 0);
    check("arb1 pc data", data_from_mem_PC, ref_mem[12'h040]);
    exp_pc = ref_mem[12'h040]; exp_ld = ref_mem[12'h050];
    clear_inputs();
    @(negedge clk);
    // After a store, fetch goes first.
    do_op(K_STORE, 16'h0060, 16'h7777, "arb2 store");
    fetch_req = 1; mem_address_PC = 16'h0070;
    loading = 1;   mem_address_load_stor = 16'h0060;
    wait_pulse(w);
    check("arb2 first is fetch", w, 0);
    check("arb2 pc data", data_from_mem_PC, ref_mem[12'h070]);
    fetch_req = 0;
    wait_pulse(w);
    check("arb2 second is ls", w, 1);
    check("arb2 ld data", data_from_mem_load, 16'h7777);
    exp_pc = ref_mem[12'h070]; exp_ld = 16'h7777;
    clear_inputs();
    @(negedge clk);

    // Reset during the ACCESS cycle of a store: write abandoned.
    storing = 1; mem_address_load_stor = 16'h0080; data_to_mem_stor = 16'h1111;
    @(negedge clk);
    check("rst-store in access we", ram_we, 1);
    reset = 0;
    #1;
    check("rst-store ram_we", ram_we, 0);
    check("rst-store busy", busy, 0);
    check("rst-store ram_addr", ram_addr, 0);
    check("rst-store data_ld", data_from_mem_load, 0);
    check("rst-store data_pc", data_from_mem_PC, 0);
    clear_inputs();
    exp_pc = '0; exp_ld = '0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    do_op(K_LOAD, 16'h0080, 16'h0000, "rst-store readback");
    check("rst-store ram unchanged", data_from_mem_load, init_val(12'h080));

    // Address change while busy must not affect the access.
    loading = 1; mem_address_load_stor = 16'h0010;
    @(negedge clk);
    mem_address_load_stor = 16'h0030;
    @(negedge clk);
    check("busy addr held", ram_addr, 12'h010);
    wait_pulse(w);
    check("busy addr pulse", w, 1);
    check("busy addr data", data_from_mem_load, ref_mem[12'h010]);
    exp_ld = ref_mem[12'h010];
    clear_inputs();
    @(negedge clk);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      ra = {4'($urandom), 8'h00, 4'($urandom)};
      wd = 16'($urandom);
      do_op(int'($urandom_range(0, 3)), ra, wd, $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
